// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, with valid/ready on both sides.
// Optional build macro SERIAL_SUB_SAT_EN clamps a borrowing result to zero (unsigned saturating subtract).
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifdef SERIAL_SUB_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic [CNT_W-1:0] r_cnt;
   logic             r_br;
   logic             r_bout;
   logic             w_a0;
   logic             w_b0;
   logic             w_d;
   logic             w_br_nxt;
   logic             w_last;
   logic [WIDTH-1:0] w_res_nxt;

   function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH-1:0] raw,
                                              input logic             borrow);
      f_sat = (SAT_EN && borrow) ? '0 : raw;
   endfunction

   assign w_a0      = r_a_sr[0];
   assign w_b0      = r_b_sr[0];
   assign w_d       = w_a0 ^ w_b0 ^ r_br;
   assign w_br_nxt  = (~w_a0 & w_b0) | (~w_a0 & r_br) | (w_b0 & r_br);
   assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
   assign w_last    = (r_cnt == CNT_LAST);

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_RUN);
   assign out_valid = (r_state == S_DONE);
   assign diff      = r_diff;
   assign bout      = r_bout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // flush outranks both acceptance and result handoff
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr <= '0;
         r_b_sr <= '0;
         r_res  <= '0;
         r_diff <= '0;
         r_cnt  <= '0;
         r_br   <= 1'b0;
         r_bout <= 1'b0;
      end else if (flush) begin
         r_cnt <= '0;
         r_br  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a_sr <= a;
                  r_b_sr <= b;
                  r_br   <= bin;
                  r_cnt  <= '0;
               end
            end
            S_RUN: begin
               r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_br   <= w_br_nxt;
               r_res  <= w_res_nxt;
               // the counter parks on its last value rather than wrapping
               if (w_last) begin
                  r_diff <= f_sat(w_res_nxt, w_br_nxt);
                  r_bout <= w_br_nxt;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8): arithmetic, latency, backpressure, flush and async reset.
module tb_serial_sub_ctrl;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       bout;
   logic       busy;

   int n_chk;
   int n_err;
   int lat;
   int bcyc;
   int ov_seen;

   serial_sub_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and wait (bounded) for out_valid, leaving the result undelivered.
   task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        output int olat, output int obusy);
      a = ta;
      b = tb;
      bin = tbin;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = ~ta;
      b = ~tb;
      bin = ~tbin;
      olat = 0;
      obusy = 0;
      while (!out_valid && olat < 40) begin
         if (busy) obusy++;
         step();
         olat++;
      end
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = 8'h00;
      b = 8'h00;
      bin = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_diff", 32'(diff), 32'h00);
      check("rst_bout", 32'(bout), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // 0x5A - 0x3C = 0x1E, latency and busy width
      issue(8'h5A, 8'h3C, 1'b0, lat, bcyc);
      check("t1_latency", 32'(lat), 32'd8);
      check("t1_busy_cycles", 32'(bcyc), 32'd8);
      check("t1_diff", 32'(diff), 32'h1E);
      check("t1_bout", 32'(bout), 32'd0);
      check("t1_busy_done", 32'(busy), 32'd0);
      handoff("t1");

      // 0x00 - 0x01 wraps (or clamps in the saturating build)
      issue(8'h00, 8'h01, 1'b0, lat, bcyc);
      check("t2_latency", 32'(lat), 32'd8);
`ifdef SERIAL_SUB_SAT_EN
      check("t2_diff", 32'(diff), 32'h00);
`else
      check("t2_diff", 32'(diff), 32'hFF);
`endif
      check("t2_bout", 32'(bout), 32'd1);
      handoff("t2");

      // 0xFF - 0xFF - 1
      issue(8'hFF, 8'hFF, 1'b1, lat, bcyc);
`ifdef SERIAL_SUB_SAT_EN
      check("t3_diff", 32'(diff), 32'h00);
`else
      check("t3_diff", 32'(diff), 32'hFF);
`endif
      check("t3_bout", 32'(bout), 32'd1);
      handoff("t3");

      // backpressure: result held 5 cycles
      issue(8'h80, 8'h7F, 1'b0, lat, bcyc);
      check("t4_latency", 32'(lat), 32'd8);
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_ov", 32'(out_valid), 32'd1);
         check("t4_hold_diff", 32'(diff), 32'h01);
         check("t4_hold_bout", 32'(bout), 32'd0);
         check("t4_hold_rdy", 32'(in_ready), 32'd0);
         step();
      end
      check("t4_ov_before", 32'(out_valid), 32'd1);
      handoff("t4");

      // flush in IDLE outranks acceptance
      a = 8'h44;
      b = 8'h11;
      bin = 1'b0;
      in_valid = 1'b1;
      flush = 1'b1;
      step();
      in_valid = 1'b0;
      flush = 1'b0;
      check("t5a_idle_rdy", 32'(in_ready), 32'd1);
      check("t5a_idle_busy", 32'(busy), 32'd0);

      // flush at RUN cycle 3
      a = 8'h10;
      b = 8'h01;
      bin = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("t5_busy_run", 32'(busy), 32'd1);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t5_flush_rdy", 32'(in_ready), 32'd1);
      check("t5_flush_busy", 32'(busy), 32'd0);
      check("t5_flush_diff_hold", 32'(diff), 32'h01);
      ov_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) ov_seen++;
         step();
      end
      check("t5_no_ov", 32'(ov_seen), 32'd0);
      issue(8'h03, 8'h02, 1'b0, lat, bcyc);
      check("t5_latency", 32'(lat), 32'd8);
      check("t5_diff", 32'(diff), 32'h01);
      check("t5_bout", 32'(bout), 32'd0);
      handoff("t5");

      // async reset at RUN cycle 4
      a = 8'h10;
      b = 8'h01;
      bin = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_ov", 32'(out_valid), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_bout", 32'(bout), 32'd0);
      check("t6_diff", 32'(diff), 32'h00);
      check("t6_rdy", 32'(in_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();
      issue(8'h22, 8'h11, 1'b0, lat, bcyc);
      check("t6_latency", 32'(lat), 32'd8);
      check("t6_diff_after", 32'(diff), 32'h11);
      check("t6_bout_after", 32'(bout), 32'd0);
      handoff("t6");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtract controller: accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake.
- Computes a - b - bin one bit per clock, LSB first, using the 1-bit full-subtractor equations.
- Returns the WIDTH-bit difference and final borrow through a valid/ready handshake.
- Sits between a requesting datapath and the result consumer. Trades WIDTH cycles of latency for a single subtractor cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns block to IDLE.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  difference result.
- bout  output  1  final borrow-out.
- busy  output  1  high while in RUN.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, diff=0, bout=0, out_valid=0, busy=0.
  - Internal shift registers, bit counter and borrow register = 0.
  - in_ready is a decode of state==IDLE, so it reads 1 while rst_n is low.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a into A_sr, b into B_sr, bin into borrow register br. Clear counter cnt and go to RUN.
- RUN (busy=1, in_ready=0), each cycle:
  - d = A_sr[0]^B_sr[0]^br.
  - br <= (~A_sr[0]&B_sr[0]) | (~A_sr[0]&br) | (B_sr[0]&br).
  - A_sr and B_sr shift right by 1.
  - d shifts into result register R from the MSB side.
  - cnt increments.
  - When cnt==WIDTH-1, the last bit is processed and the state moves to DONE.
- Latency: acceptance edge at T; out_valid rises at edge T+WIDTH; exactly WIDTH RUN cycles.
- DONE:
  - out_valid=1; diff=R and bout=br, stable until handshake.
  - On out_valid&&out_ready, go to IDLE; out_valid=0 the next cycle.
  - No new operand is accepted in the same cycle as result handoff; minimum issue interval is WIDTH+2 cycles.
- Backpressure: out_ready low in DONE holds diff/bout/out_valid unchanged indefinitely.
- Operands: a/b/bin changes while not in IDLE are ignored.
- flush:
  - Sampled every cycle; forces state to IDLE and out_valid=0 on the next edge.
  - Clears cnt and br; diff/bout hold their last value.
  - flush has priority over acceptance and handoff in the same cycle.
- Asynchronous reset mid-RUN or mid-DONE: immediate return to reset values; the in-flight result is lost.
- Arithmetic: result is modulo 2^WIDTH. bout=1 exactly when a < b+bin as unsigned values.
- Counter width: $clog2(WIDTH) bits; no wrap beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_SAT_EN.
- Defined:
  - On entering DONE with final borrow=1, diff is forced to all-zeros (unsigned saturating subtract).
  - bout still reports 1.
- Undefined: diff is the raw modulo-2^WIDTH result.
- Latency and handshake are identical in both builds.

Test Plan:
- WIDTH=8:
  - a=0x5A, b=0x3C, bin=0, accepted at edge T
  - -> out_valid at T+8, diff=0x1E, bout=0, busy high for exactly 8 cycles.
- a=0x00, b=0x01, bin=0
  - -> diff=0xFF, bout=1.
  - With SERIAL_SUB_SAT_EN defined: diff=0x00, bout=1.
- a=0xFF, b=0xFF, bin=1
  - -> diff=0xFF, bout=1.
- a=0x80, b=0x7F, bin=0, out_ready held low 5 cycles after out_valid
  - -> diff=0x01, bout=0 held stable.
  - in_ready=0 throughout; handoff on the first out_ready=1 cycle.
  - in_ready=1 on the following cycle.
- Start a=0x10, b=0x01; assert flush at RUN cycle 3
  - -> IDLE next edge, out_valid never rises.
  - A following request a=0x03, b=0x02 -> diff=0x01, bout=0.
- Drop rst_n low asynchronously mid-RUN (cycle 4)
  - -> out_valid=0, busy=0, bout=0, diff=0 immediately, in_ready=1.
  - After release, a=0x22, b=0x11 -> diff=0x11, bout=0.
